// File: rtl/writeback_encoder_pkg.sv
// Shared register-file writeback constants and the encoder FSM state encoding.
package writeback_encoder_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } wb_state_e;

endpackage : writeback_encoder_pkg

// File: rtl/writeback_encoder_if.sv
// Request/issue bus between the writeback sources, the encoder and the register-file write port.
interface writeback_encoder_if;
  import writeback_encoder_pkg::*;

  logic [NUM_REGS-1:0] req;
  logic                req_valid;
  logic                flush;
  logic                out_ready;
  logic [ADDR_W-1:0]   addr;
  logic                load_enable;
  logic [NUM_REGS-1:0] pending;
  logic                dup_err;

  // Encoder side: consumes requests and back-pressure, drives the write address.
  modport master (
    input  req, req_valid, flush, out_ready,
    output addr, load_enable, pending, dup_err
  );

  // Environment side: requesters plus the register-file write port.
  modport slave (
    output req, req_valid, flush, out_ready,
    input  addr, load_enable, pending, dup_err
  );

endinterface : writeback_encoder_if

// File: rtl/writeback_encoder_rr_priority_select.sv
// Finds the first set mask bit at or above start_i, wrapping from the top index back to 0.
module rr_priority_select
  import writeback_encoder_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask_i,
  input  logic [ADDR_W-1:0]   start_i,
  output logic                found_c_o,
  output logic [ADDR_W-1:0]   idx_c_o
);

  logic [ADDR_W-1:0] cand;

  always_comb begin
    found_c_o = 1'b0;
    idx_c_o   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cand = start_i + ADDR_W'(i);
      if (!found_c_o && mask_i[cand]) begin
        found_c_o = 1'b1;
        idx_c_o   = cand;
      end
    end
  end

endmodule : rr_priority_select

// File: rtl/writeback_encoder.sv
// Round-robin writeback address encoder feeding the register-file write port.
// Define WB_ENCODER_FIXED_PRIO_EN to always pick the lowest pending register instead.
module writeback_encoder
  import writeback_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  writeback_encoder_if.master bus
);

  wb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                load_enable_q, load_enable_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                dup_err_q, dup_err_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;

  logic                accept_c;
  logic [NUM_REGS-1:0] clr_c;
  logic [NUM_REGS-1:0] pend_nxt_c;
  logic [ADDR_W-1:0]   next_start_c;
  logic [NUM_REGS-1:0] sel_mask_c;
  logic [ADDR_W-1:0]   sel_start_c;
  logic                sel_found_c;
  logic [ADDR_W-1:0]   sel_idx_c;

  // Accepted address is cleared, but a same-cycle request for it wins.
  assign accept_c   = load_enable_q & bus.out_ready;
  assign clr_c      = accept_c ? (NUM_REGS'(1) << addr_q) : '0;
  assign pend_nxt_c = (pending_q & ~clr_c) | (bus.req_valid ? bus.req : '0);

`ifdef WB_ENCODER_FIXED_PRIO_EN
  assign next_start_c = '0;
`else
  assign next_start_c = addr_q + ADDR_W'(1);
`endif

  // IDLE picks from the registered mask; an accept picks the follow-on from the updated mask.
  assign sel_mask_c  = accept_c ? pend_nxt_c   : pending_q;
  assign sel_start_c = accept_c ? next_start_c : ptr_q;

  rr_priority_select u_sel (
    .mask_i    (sel_mask_c),
    .start_i   (sel_start_c),
    .found_c_o (sel_found_c),
    .idx_c_o   (sel_idx_c)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    load_enable_d = load_enable_q;
    ptr_d         = ptr_q;
    pending_d     = pend_nxt_c;
    dup_err_d     = dup_err_q |
                    (bus.req_valid & ~bus.flush & (|(bus.req & pending_q & ~clr_c)));

    case (state_q)
      IDLE: begin
        load_enable_d = 1'b0;
        if (sel_found_c) begin
          addr_d        = sel_idx_c;
          load_enable_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (accept_c) begin
          ptr_d = next_start_c;
          if (sel_found_c) begin
            addr_d = sel_idx_c;
          end else begin
            load_enable_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: begin
        load_enable_d = 1'b0;
        state_d       = IDLE;
      end
    endcase

    // Flush drops everything in flight, including this cycle's request and accept bookkeeping.
    if (bus.flush) begin
      pending_d     = '0;
      load_enable_d = 1'b0;
      state_d       = IDLE;
      ptr_d         = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      load_enable_q <= 1'b0;
      pending_q     <= '0;
      dup_err_q     <= 1'b0;
      ptr_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      load_enable_q <= load_enable_d;
      pending_q     <= pending_d;
      dup_err_q     <= dup_err_d;
      ptr_q         <= ptr_d;
    end
  end

  assign bus.addr        = addr_q;
  assign bus.load_enable = load_enable_q;
  assign bus.pending     = pending_q;
  assign bus.dup_err     = dup_err_q;

endmodule : writeback_encoder

// File: tb/tb_writeback_encoder.sv
// Directed bench for writeback_encoder; expectations follow WB_ENCODER_FIXED_PRIO_EN when defined.
module tb_writeback_encoder;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  writeback_encoder_if bus ();

  writeback_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] r, input logic v, input logic f, input logic rdy);
    bus.req       = r;
    bus.req_valid = v;
    bus.flush     = f;
    bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] a, input logic le);
    check_eq({tag, ".addr"}, 32'(bus.addr), 32'(a));
    check_eq({tag, ".le"}, 32'(bus.load_enable), 32'(le));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    drive(16'h0, 1'b0, 1'b0, 1'b0);

    // Reset values, then quiet idle
    #1;
    check_out("rst", 4'd0, 1'b0);
    check_eq("rst.pending", 32'(bus.pending), 32'h0);
    check_eq("rst.dup", 32'(bus.dup_err), 32'h0);
    #9;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_out("idle", 4'd0, 1'b0);
      check_eq("idle.pending", 32'(bus.pending), 32'h0);
    end

    // Single request for register 5
    drive(16'h0020, 1'b1, 1'b0, 1'b1);
    step();
    check_eq("single.pending", 32'(bus.pending), 32'h0020);
    check_eq("single.le0", 32'(bus.load_enable), 32'h0);
    drive(16'h0, 1'b0, 1'b0, 1'b1);
    step();
    check_out("single.issue", 4'd5, 1'b1);
    step();
    check_eq("single.le_off", 32'(bus.load_enable), 32'h0);
    check_eq("single.drained", 32'(bus.pending), 32'h0);

    // Round-robin and wrap: bit 0 injected while register 1 is accepted
    do_reset();
    drive(16'h8003, 1'b1, 1'b0, 1'b1);
    step();
    check_eq("rr.pending", 32'(bus.pending), 32'h8003);
    drive(16'h0, 1'b0, 1'b0, 1'b1);
    step();
    check_out("rr.a0", 4'd0, 1'b1);
    step();
    check_out("rr.a1", 4'd1, 1'b1);
    drive(16'h0001, 1'b1, 1'b0, 1'b1);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b1);
`ifdef WB_ENCODER_FIXED_PRIO_EN
    check_out("rr.a2", 4'd0, 1'b1);
    step();
    check_out("rr.a3", 4'd15, 1'b1);
`else
    check_out("rr.a2", 4'd15, 1'b1);
    step();
    check_out("rr.a3", 4'd0, 1'b1);
`endif
    step();
    check_eq("rr.le_off", 32'(bus.load_enable), 32'h0);
    check_eq("rr.dup", 32'(bus.dup_err), 32'h0);

    // Back-pressure holds the grant stable
    do_reset();
    drive(16'h0009, 1'b1, 1'b0, 1'b0);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("bp.first", 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("bp.hold", 4'd0, 1'b1);
    end
    drive(16'h0, 1'b0, 1'b0, 1'b1);
    step();
    check_out("bp.next", 4'd3, 1'b1);

    // Same-cycle set and clear of register 3 keeps it pending without dup_err
    drive(16'h0008, 1'b1, 1'b0, 1'b1);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b1);
    check_out("setclr.reissue", 4'd3, 1'b1);
    check_eq("setclr.pending", 32'(bus.pending), 32'h0008);
    check_eq("setclr.dup", 32'(bus.dup_err), 32'h0);
    step();
    check_eq("setclr.le_off", 32'(bus.load_enable), 32'h0);

    // Duplicate request for an already pending register
    drive(16'h0004, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("dup.none_yet", 32'(bus.dup_err), 32'h0);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("dup.set", 32'(bus.dup_err), 32'h1);
    check_out("dup.issue", 4'd2, 1'b1);
    step();
    check_eq("dup.sticky", 32'(bus.dup_err), 32'h1);

    // Flush beats a same-cycle request
    drive(16'hFFFF, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("flush.full", 32'(bus.pending), 32'hFFFF);
    check_out("flush.held", 4'd2, 1'b1);
    drive(16'h00F0, 1'b1, 1'b1, 1'b0);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("flush.pending", 32'(bus.pending), 32'h0);
    check_eq("flush.le", 32'(bus.load_enable), 32'h0);
    step();
    check_eq("flush.stays", 32'(bus.pending), 32'h0);
    check_eq("flush.dup_sticky", 32'(bus.dup_err), 32'h1);

    // Full drain in 16 back-to-back cycles, starting from the pointer flush left alone
    drive(16'hFFFF, 1'b1, 1'b0, 1'b1);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b1);
    check_eq("drain.pending", 32'(bus.pending), 32'hFFFF);
    for (int i = 0; i < 16; i++) begin
      step();
`ifdef WB_ENCODER_FIXED_PRIO_EN
      check_out("drain", 4'(i), 1'b1);
`else
      check_out("drain", 4'((i + 4) % 16), 1'b1);
`endif
    end
    step();
    check_eq("drain.le_off", 32'(bus.load_enable), 32'h0);
    check_eq("drain.empty", 32'(bus.pending), 32'h0);

    // Reset in the middle of a stalled transfer
    drive(16'h0010, 1'b1, 1'b0, 1'b0);
    step();
    drive(16'h0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("midrst.pre", 4'd4, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("midrst", 4'd0, 1'b0);
    check_eq("midrst.pending", 32'(bus.pending), 32'h0);
    check_eq("midrst.dup", 32'(bus.dup_err), 32'h0);
    reset_n = 1'b1;
    step();
    check_eq("midrst.idle", 32'(bus.load_enable), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_writeback_encoder
